// File: rtl/accessmem.sv
// accessmem: shared instruction/data word memory with two registered read
// ports (fetch port at pc, data port at address) and one write port.
// Both read ports are read-first: a read at the address being written
// returns the old word, and the new word is visible one edge later.
// Optional macro ACCESSMEM_FWD_EN: when defined, a fetch that hits the word
// being written in the same cycle returns the incoming write data on ir.
// Reset is synchronous and active-low. It clears the output registers and
// blocks any write in that cycle, but it leaves the memory contents intact.

module accessmem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  rst_n
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage starts at zero and is never cleared by reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] ir_d;
    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;
    logic                  writeEn;
    logic                  fetchHit;

    // Decode the write qualifier and next output words from the current memory contents.
    always_comb begin
        writeEn  = rst_n && (wren == 1'b1);
        fetchHit = writeEn && (pc == address);
        q_d      = mem_q[address];
`ifdef ACCESSMEM_FWD_EN
        ir_d     = fetchHit ? data : mem_q[pc];
`else
        ir_d     = mem_q[pc];
`endif
    end

    // Single write port into the shared storage.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem_q[address] <= data;
        end
    end

    // Registered read outputs, cleared while reset is held low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_q <= '0;
            q_q  <= '0;
        end else begin
            ir_q <= ir_d;
            q_q  <= q_d;
        end
    end

    assign ir = ir_q;
    assign q  = q_q;

endmodule

// File: tb/tb_accessmem.sv
// tb_accessmem: directed and randomized bench for accessmem.
// A word-array model predicts ir and q after each clock edge.
// The model also honours ACCESSMEM_FWD_EN when that macro is defined.

module tb_accessmem;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
`ifdef ACCESSMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          wren;
    logic [DW-1:0] ir;
    logic [DW-1:0] q;

    int compareCount = 0;
    int failCount    = 0;

    logic [DW-1:0] refMem [DEPTH];
    logic [DW-1:0] refIr;
    logic [DW-1:0] refQ;

    always #5 clk = ~clk;

    accessmem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .pc      (pc),
        .address (address),
        .data    (data),
        .wren    (wren),
        .clk     (clk),
        .ir      (ir),
        .q       (q),
        .rst_n   (rst_n)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, advance the model at the edge, then compare both outputs.
    task automatic applyStimulus(input string tag, input logic r, input logic [AW-1:0] p,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic w);
        rst_n   = r;
        pc      = p;
        address = a;
        data    = d;
        wren    = w;
        @(posedge clk);
        if (!r) begin
            refIr = '0;
            refQ  = '0;
        end else begin
            refQ  = refMem[a];
            refIr = (FWD && w && (p == a)) ? d : refMem[p];
            if (w) refMem[a] = d;
        end
        #1;
        checkOutput({tag, ".ir"}, ir, refIr);
        checkOutput({tag, ".q"}, q, refQ);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        refIr = '0;
        refQ  = '0;

        // Reset with a pending write that must be ignored.
        applyStimulus("reset0", 1'b0, 8'h00, 8'h05, 32'hDEADBEEF, 1'b1);
        applyStimulus("reset1", 1'b0, 8'h00, 8'h05, 32'hDEADBEEF, 1'b1);
        checkOutput("reset.irZero", ir, 32'h0);
        checkOutput("reset.qZero", q, 32'h0);
        applyStimulus("read05", 1'b1, 8'h05, 8'h05, 32'h0, 1'b0);
        checkOutput("read05.noWrite", q, 32'h0);

        // Write then read on the data port: old word on the write edge.
        applyStimulus("wr01a", 1'b1, 8'h00, 8'h01, 32'h11111111, 1'b0);
        applyStimulus("wr01b", 1'b1, 8'h00, 8'h01, 32'h11111111, 1'b1);
        checkOutput("wr01b.oldWord", q, 32'h0);
        applyStimulus("wr01c", 1'b1, 8'h00, 8'h01, 32'h11111111, 1'b0);
        checkOutput("wr01c.newWord", q, 32'h11111111);

        // Fetch after write.
        applyStimulus("wr10", 1'b1, 8'h00, 8'h10, 32'hA5A5A5A5, 1'b1);
        applyStimulus("fetch10", 1'b1, 8'h10, 8'h00, 32'h0, 1'b0);
        checkOutput("fetch10.ir", ir, 32'hA5A5A5A5);

        // Fetch/write collision.
        applyStimulus("coll", 1'b1, 8'h20, 8'h20, 32'h12345678, 1'b1);
        checkOutput("coll.irConst", ir, FWD ? 32'h12345678 : 32'h0);
        checkOutput("coll.qConst", q, 32'h0);
        applyStimulus("coll2", 1'b1, 8'h20, 8'h20, 32'h0, 1'b0);
        checkOutput("coll2.ir", ir, 32'h12345678);

        // Address boundaries, no aliasing between the first and last words.
        applyStimulus("wrFF", 1'b1, 8'h00, 8'hFF, 32'hFFFFFFFF, 1'b1);
        applyStimulus("wr00", 1'b1, 8'h00, 8'h00, 32'h00000001, 1'b1);
        applyStimulus("rdFF00", 1'b1, 8'hFF, 8'h00, 32'h0, 1'b0);
        checkOutput("rdFF00.ir", ir, 32'hFFFFFFFF);
        checkOutput("rdFF00.q", q, 32'h00000001);
        applyStimulus("rd00FF", 1'b1, 8'h00, 8'hFF, 32'h0, 1'b0);
        checkOutput("rd00FF.q", q, 32'hFFFFFFFF);

        // Reset mid-run keeps memory contents.
        applyStimulus("rstMid", 1'b0, 8'h10, 8'h10, 32'h00000BAD, 1'b1);
        checkOutput("rstMid.ir", ir, 32'h0);
        applyStimulus("postRst", 1'b1, 8'h10, 8'h01, 32'h0, 1'b0);
        checkOutput("postRst.ir", ir, 32'hA5A5A5A5);
        checkOutput("postRst.q", q, 32'h11111111);

        // Randomized traffic with frequent collisions and occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] rp;
            logic [AW-1:0] ra;
            rp = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? rp : AW'($urandom_range(0, DEPTH - 1));
            applyStimulus("rand", ($urandom_range(0, 19) != 0), rp, ra, $urandom,
                          ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/accessmem.md
ACCESSMEM -- requirements
Module: accessmem

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width of memory, data, ir and q SHALL be DATA_WIDTH bits.
REQ-002 Parameter ADDR_WIDTH, default 8: width of pc and address; memory depth SHALL be 2**ADDR_WIDTH words (256 by default).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port pc, input, ADDR_WIDTH: instruction-fetch word address (read-only port).
REQ-006 Port address, input, ADDR_WIDTH: data-port word address for read and write.
REQ-007 Port data, input, DATA_WIDTH: write data for the data port.
REQ-008 Port wren, input, 1: data-port write enable, active-high.
REQ-009 Port ir, output, DATA_WIDTH: registered instruction word read at pc.
REQ-010 Port q, output, DATA_WIDTH: registered data word read at address.
REQ-011 Positional port order SHALL be pc, address, data, wren, clk, ir, q, rst_n.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH words of DATA_WIDTH bits, shared by both ports.
REQ-013 Memory contents SHALL be zero at simulation start and SHALL persist until overwritten.
REQ-014 Edge with rst_n=1 and wren=1: mem[address] <= data.
REQ-015 Edge with rst_n=1 and wren=0: memory SHALL be unchanged.
REQ-016 Edge with rst_n=1: ir <= mem[pc] and q <= mem[address]; read latency exactly one clock; outputs hold between edges.
REQ-017 Data-port read-during-write at same address: q SHALL return the pre-write (old) word; new word visible on q one edge later.
REQ-018 Instruction-port collision (wren=1, pc==address): ir behaviour per REQ-024/REQ-025.
REQ-019 Both ports SHALL be readable every cycle with no stall, no handshake, independent addresses.
REQ-020 Address wrap: addresses are exact ADDR_WIDTH-bit indices; no out-of-range case; 0xFF is the last word.
REQ-021 Unknown (X) wren SHALL NOT be treated as a write.

Reset
REQ-022 Edge with rst_n=0: ir <= 0, q <= 0, and any write that cycle SHALL be suppressed.
REQ-023 Reset SHALL NOT clear memory contents; after rst_n returns to 1, the first edge resumes normal reads.

Configuration
REQ-024 With macro ACCESSMEM_FWD_EN defined: on a REQ-018 collision, ir SHALL return the new data (write-to-fetch forwarding).
REQ-025 Without ACCESSMEM_FWD_EN: on a REQ-018 collision, ir SHALL return the old word, same as q (read-first).

Verification
REQ-026 Reset: rst_n=0 for 2 edges with wren=1, address=0x05, data=0xDEADBEEF -> ir=q=0; later read of 0x05 returns 0x00000000.
REQ-027 Write/read: rst_n=1, pc=0x00, address=0x01, data=0x11111111, wren=0 one edge -> q=0, ir=0; then wren=1 -> q stays 0 on write edge (old data), q=0x11111111 on the next edge.
REQ-028 Fetch after write: write 0xA5A5A5A5 to 0x10, then pc=0x10, wren=0 -> ir=0xA5A5A5A5 one edge later.
REQ-029 Collision: pc=address=0x20, data=0x12345678, wren=1 -> ir=0x12345678 with ACCESSMEM_FWD_EN, ir=0x00000000 without; q=0x00000000 in both builds.
REQ-030 Boundary: write 0xFFFFFFFF to 0xFF and 0x00000001 to 0x00 -> reading 0xFF and 0x00 returns those values; no aliasing.
REQ-031 Reset mid-run: memory written, rst_n=0 one edge -> outputs 0; after release, reads return pre-reset contents.
